// File: rtl/clk_lock_supervisor.sv
// Per-channel MMCM/PLL lock supervisor: timed reset pulses, lock timeout, bounded retry.
// Optional feature: define CLK_SUP_LOSS_CNT_EN to add per-channel loss-of-lock counters.
module clk_lock_supervisor #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_CH-1:0]   lock_in,
    input  logic [N_CH-1:0]   rearm,
    input  logic [N_CH-1:0]   ch_mask,
    output logic [N_CH-1:0]   mmcm_rst,
    output logic [N_CH-1:0]   ch_locked,
    output logic [N_CH-1:0]   ch_fail,
    output logic              all_locked
`ifdef CLK_SUP_LOSS_CNT_EN
    ,
    output logic [8*N_CH-1:0] loss_cnt
`endif
);

    localparam int unsigned CycMax = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned CycW   = $clog2(CycMax + 1);
    localparam int unsigned StabW  = $clog2(LOCK_STABLE + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StReset  = 3'd1;
    localparam logic [2:0] StWait   = 3'd2;
    localparam logic [2:0] StLocked = 3'd3;
    localparam logic [2:0] StFailed = 3'd4;

    // Asynchronous assertion, synchronised release.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] lk;

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= lock_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [2:0]        st_q, st_d;
        logic [CycW-1:0]   cyc_q, cyc_d;
        logic [StabW-1:0]  stab_q, stab_d;
        logic [RetryW-1:0] retry_q, retry_d, retry_inc;
        logic              mrst_q, locked_q, fail_q;

        assign retry_inc = retry_q + 1'b1;

        always_comb begin
            st_d    = st_q;
            cyc_d   = cyc_q;
            stab_d  = stab_q;
            retry_d = retry_q;
            if (!start) begin
                st_d    = StIdle;
                cyc_d   = '0;
                stab_d  = '0;
                retry_d = '0;
            end else begin
                case (st_q)
                    StIdle: begin
                        st_d    = StReset;
                        cyc_d   = '0;
                        retry_d = '0;
                    end
                    StReset: begin
                        if (cyc_q == CycW'(RST_CYCLES - 1)) begin
                            st_d   = StWait;
                            cyc_d  = '0;
                            stab_d = '0;
                        end else begin
                            cyc_d = cyc_q + 1'b1;
                        end
                    end
                    StWait: begin
                        cyc_d  = cyc_q + 1'b1;
                        stab_d = lk[i] ? stab_q + 1'b1 : '0;
                        // Stability is tested first so it wins a same-cycle timeout.
                        if (lk[i] && stab_q == StabW'(LOCK_STABLE - 1)) begin
                            st_d = StLocked;
                        end else if (cyc_q == CycW'(LOCK_TIMEOUT - 1)) begin
                            retry_d = retry_inc;
                            cyc_d   = '0;
                            stab_d  = '0;
                            st_d    = (retry_inc == RetryW'(MAX_RETRY)) ? StFailed : StReset;
                        end
                    end
                    StLocked: begin
                        if (!lk[i]) begin
                            st_d    = StReset;
                            retry_d = '0;
                            cyc_d   = '0;
                            stab_d  = '0;
                        end
                    end
                    StFailed: begin
                        if (rearm[i]) begin
                            st_d    = StReset;
                            retry_d = '0;
                            cyc_d   = '0;
                        end
                    end
                    default: st_d = StIdle;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int) begin
                st_q     <= StIdle;
                cyc_q    <= '0;
                stab_q   <= '0;
                retry_q  <= '0;
                mrst_q   <= 1'b1;
                locked_q <= 1'b0;
                fail_q   <= 1'b0;
            end else begin
                st_q     <= st_d;
                cyc_q    <= cyc_d;
                stab_q   <= stab_d;
                retry_q  <= retry_d;
                mrst_q   <= (st_d == StIdle) || (st_d == StReset) || (st_d == StFailed);
                locked_q <= (st_d == StLocked);
                fail_q   <= (st_d == StFailed);
            end
        end

        assign mmcm_rst[i]  = mrst_q;
        assign ch_locked[i] = locked_q;
        assign ch_fail[i]   = fail_q;

`ifdef CLK_SUP_LOSS_CNT_EN
        logic       loss_ev;
        logic [7:0] loss_q;

        assign loss_ev = start && (st_q == StLocked) && !lk[i];

        always_ff @(posedge clk or posedge rst_int) begin
            if (rst_int) begin
                loss_q <= '0;
            end else if (rearm[i]) begin
                loss_q <= '0;
            end else if (loss_ev && loss_q != 8'hFF) begin
                loss_q <= loss_q + 1'b1;
            end
        end

        assign loss_cnt[8*i +: 8] = loss_q;
`endif
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            all_locked <= 1'b0;
        end else begin
            all_locked <= (|ch_mask) && (&(ch_locked | ~ch_mask));
        end
    end

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Directed, table-driven bench for clk_lock_supervisor (default parameters).
module tb_clk_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] lock_in;
    logic [3:0] rearm;
    logic [3:0] ch_mask;
    logic [3:0] mmcm_rst;
    logic [3:0] ch_locked;
    logic [3:0] ch_fail;
    logic       all_locked;
`ifdef CLK_SUP_LOSS_CNT_EN
    logic [31:0] loss_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    clk_lock_supervisor dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lock_in    (lock_in),
        .rearm      (rearm),
        .ch_mask    (ch_mask),
        .mmcm_rst   (mmcm_rst),
        .ch_locked  (ch_locked),
        .ch_fail    (ch_fail),
        .all_locked (all_locked)
`ifdef CLK_SUP_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [3:0] lock;
        logic [3:0] mask;
        int         n;
        logic [3:0] e_mrst;
        logic [3:0] e_lk;
        logic [3:0] e_fail;
        logic       e_all;
        logic [7:0] e_loss;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic [3:0] l, input logic [3:0] m, input int n,
                       input logic [3:0] em, input logic [3:0] el, input logic [3:0] ef,
                       input logic ea, input logic [7:0] eloss);
        vec_t v;
        v.s = s; v.lock = l; v.mask = m; v.n = n;
        v.e_mrst = em; v.e_lk = el; v.e_fail = ef; v.e_all = ea; v.e_loss = eloss;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] em, input logic [3:0] el,
                              input logic [3:0] ef, input logic ea);
        check({tag, " mmcm_rst"}, 32'(mmcm_rst), 32'(em));
        check({tag, " ch_locked"}, 32'(ch_locked), 32'(el));
        check({tag, " ch_fail"}, 32'(ch_fail), 32'(ef));
        check({tag, " all_locked"}, 32'(all_locked), 32'(ea));
    endtask

    int exp_fall[3] = '{17, 1057, 2097};
    int exp_rise[3] = '{1041, 2081, 3121};

    initial begin
        int   fall_t[$];
        int   rise_t[$];
        int   fail_t;
        logic prev;

        // Nominal lock: WAIT_LOCK entered 17 edges after START, lk high 2 edges later.
        add(1, 4'h0, 4'hF, 16, 4'hF, 4'h0, 4'h0, 0, 8'd0);
        add(1, 4'h0, 4'hF, 1,  4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(1, 4'hF, 4'hF, 65, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 0, 8'd0);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd0);
        add(1, 4'hF, 4'h0, 1,  4'h0, 4'hF, 4'h0, 0, 8'd0);
        add(1, 4'hF, 4'h5, 1,  4'h0, 4'hF, 4'h0, 1, 8'd0);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd0);
        // Single-cycle glitch on channel 0, then relock.
        add(1, 4'hE, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd0);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd0);
        add(1, 4'hF, 4'hF, 1,  4'h1, 4'hE, 4'h0, 1, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h1, 4'hE, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 78, 4'h0, 4'hE, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd1);
        // Abort from LOCKED.
        add(0, 4'hF, 4'hF, 1,  4'hF, 4'h0, 4'h0, 1, 8'd1);
        add(0, 4'hF, 4'hF, 1,  4'hF, 4'h0, 4'h0, 0, 8'd1);
        // Restart, then abort from WAIT_LOCK.
        add(1, 4'hF, 4'hF, 16, 4'hF, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 30, 4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'hF, 4'hF, 1,  4'hF, 4'h0, 4'h0, 0, 8'd1);
        // Stability restart on channel 2: 63 lk-high edges, one low, then a fresh window.
        add(1, 4'hB, 4'hF, 16, 4'hF, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'hB, 4'hF, 1,  4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 63, 4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'hB, 4'hF, 1,  4'h0, 4'hB, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 65, 4'h0, 4'hB, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 0, 8'd1);
        add(1, 4'hF, 4'hF, 1,  4'h0, 4'hF, 4'h0, 1, 8'd1);
        add(0, 4'hF, 4'hF, 2,  4'hF, 4'h0, 4'h0, 0, 8'd1);

        rst = 1'b1;
        start = 1'b0;
        lock_in = 4'h0;
        rearm = 4'h0;
        ch_mask = 4'hF;
        adv(2);
        check_outs("reset", 4'hF, 4'h0, 4'h0, 1'b0);
        rst = 1'b0;
        adv(4);
        check_outs("idle", 4'hF, 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].s;
            lock_in = vecs[i].lock;
            ch_mask = vecs[i].mask;
            adv(vecs[i].n);
            check_outs($sformatf("v%0d", i), vecs[i].e_mrst, vecs[i].e_lk, vecs[i].e_fail,
                       vecs[i].e_all);
`ifdef CLK_SUP_LOSS_CNT_EN
            check($sformatf("v%0d loss_cnt0", i), 32'(loss_cnt[7:0]), 32'(vecs[i].e_loss));
`endif
        end

        // Retry exhaustion: channel 1 never locks; record its reset edges.
        start = 1'b1;
        lock_in = 4'hD;
        ch_mask = 4'hD;
        fail_t = -1;
        prev = 1'b1;
        for (int k = 1; k <= 3130; k++) begin
            @(posedge clk);
            #1;
            if (prev && !mmcm_rst[1]) fall_t.push_back(k);
            if (!prev && mmcm_rst[1]) rise_t.push_back(k);
            if (ch_fail[1] && fail_t < 0) fail_t = k;
            prev = mmcm_rst[1];
        end
        check("retry falls", 32'(fall_t.size()), 32'd3);
        check("retry rises", 32'(rise_t.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("retry fall%0d", i),
                  (i < fall_t.size()) ? fall_t[i] : -1, exp_fall[i]);
            check($sformatf("retry rise%0d", i),
                  (i < rise_t.size()) ? rise_t[i] : -1, exp_rise[i]);
        end
        check("retry fail time", fail_t, 32'd3121);
        check_outs("failed", 4'h2, 4'hD, 4'h2, 1'b1);

        // Rearm channel 1; rearm on locked channel 0 must be ignored by its FSM.
        lock_in = 4'hF;
        rearm = 4'h3;
        adv(1);
        rearm = 4'h0;
        check_outs("rearm", 4'h2, 4'hD, 4'h0, 1'b1);
`ifdef CLK_SUP_LOSS_CNT_EN
        check("rearm loss_cnt0", 32'(loss_cnt[7:0]), 32'd0);
`endif
        adv(15);
        check("rearm rst end", 32'(mmcm_rst), 32'h2);
        adv(1);
        check("rearm wait", 32'(mmcm_rst), 32'h0);
        adv(63);
        check("rearm pre-lock", 32'(ch_locked), 32'hD);
        adv(1);
        check("rearm lock", 32'(ch_locked), 32'hF);

        // Asynchronous reset mid-cycle.
        #3;
        rst = 1'b1;
        #1;
        check_outs("async rst", 4'hF, 4'h0, 4'h0, 1'b0);
        adv(2);
        rst = 1'b0;
        adv(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
